detection_collector: RTL and testbench
======================================

Name: detection_collector

Overview:
- Downstream consumer of the cascade classifier's per-window result stream.
- Tracks the window position (x, y, scale) of every classified window using row and scale end markers carried alongside the result.
- Buffers positive detections as coordinate records in an internal FIFO and emits them to the host or readout stage over a valid/ready stream.
- Always emits one record for the final window of each frame, marked with det_last.

Parameters:
- IMG_WIDTH, 45, image width in pixels at scale 0.
- IMG_HEIGHT, 45, image height in pixels at scale 0.
- FEATURE_WIDTH, 25, window width.
- FEATURE_HEIGHT, 25, window height.
- SCALE_NUM, 2, number of scales per frame.
- FIFO_DEPTH, 8, record FIFO entries; must be a power of 2 and at least 2.
- Derived widths:
  - W_X = $clog2(IMG_WIDTH-FEATURE_WIDTH+1)
  - W_Y = $clog2(IMG_HEIGHT-FEATURE_HEIGHT+1)
  - W_S = max(1, $clog2(SCALE_NUM))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- result_valid  in  1  classifier result valid
- result_ready  out  1  collector can accept a result
- result_data  in  1  1 = window passed all stages
- result_eot  in  2  bit0 = last window of row; bit1 = last window of scale (bit1 implies bit0)
- det_valid  out  1  record available
- det_ready  in  1  consumer accepts record
- det_x  out  W_X  window column
- det_y  out  W_Y  window row
- det_scale  out  W_S  scale index
- det_hit  out  1  window was positive
- det_last  out  1  last window of frame
- err_geom  out  1  sticky geometry error

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - det_valid=0, err_geom=0.
  - x, y, scale counters = 0.
  - FIFO empty; det_* data outputs = 0.
- Accept and drop rules:
  - Accept happens on result_valid && result_ready.
  - result_ready = !fifo_full. It is independent of result_data and of det_ready, with no pass-through when full.
  - A negative, non-last window is accepted and dropped; it only advances the counters.
- Record push rule:
  - On accept, push {x, y, scale, hit=result_data, last=frame_end} when result_data==1 or frame_end==1.
  - frame_end = result_eot[1] && scale==SCALE_NUM-1.
  - The pushed coordinates are the counter values before update.
- Counter update on accept (priority order):
  - eot[1]: x=0, y=0. scale increments, or wraps to 0 on frame_end.
  - else eot[0]: x=0, y=y+1.
  - else: x=x+1.
- Geometry errors (set err_geom, sticky until rst):
  - x would exceed IMG_WIDTH-FEATURE_WIDTH: x saturates, err set.
  - y would exceed IMG_HEIGHT-FEATURE_HEIGHT: y saturates, err set.
  - eot[1] arrives without eot[0]: treated as eot[1], err set.
  - Processing continues after any error.
- FIFO:
  - Registered output; a record pushed in cycle N is visible on det_* in cycle N+1 at the earliest.
  - Pop on det_valid && det_ready.
  - Simultaneous push and pop is allowed when not full; occupancy is unchanged.
  - Simultaneous push and pop with the FIFO full cannot occur, because result_ready=0 when full.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - det_* outputs are held stable while det_valid && !det_ready.
- Mid-frame reset: counters, FIFO and err_geom clear immediately. The next accepted result is treated as x=0, y=0, scale=0.

Optional Feature:
- Macro: DETECTION_COLLECTOR_STATS_EN.
- When defined:
  - Adds output frame_hits, width $clog2(SCALE_NUM*(IMG_WIDTH-FEATURE_WIDTH+1)*(IMG_HEIGHT-FEATURE_HEIGHT+1)+1).
  - An internal counter increments on each accepted positive window and saturates.
  - On the frame_end accept, frame_hits is loaded with the final count, including the current window, and the internal counter clears.
  - frame_hits resets to 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Frame with all-negative windows (21x21 windows at scale 0, then scale 1 as sized by the classifier's eot markers), det_ready=1 -> exactly one record {x=last col, y=last row, scale=1, hit=0, last=1}; err_geom=0.
- Positive at scale 0, window 4 of row 2 -> record {x=4, y=2, scale=0, hit=1, last=0} on det_* one cycle after accept.
- det_ready=0 with 9 positive windows, FIFO_DEPTH=8 -> result_ready drops after the 8th accept. Raising det_ready restores result_ready the cycle after the first pop, and all 9 records appear in order.
- 22 windows in a row without eot[0] -> x saturates at 20, err_geom=1 and stays 1 until rst.
- Reset asserted mid-frame with 3 records queued -> det_valid=0 next cycle; the next positive window reports x=0, y=0, scale=0.
- With DETECTION_COLLECTOR_STATS_EN defined, 5 positive windows in a frame, the last window positive -> frame_hits=5 after the frame_end accept; the next frame with 0 hits gives frame_hits=0.

Source files
------------

// File: rtl/detection_collector.sv
// detection_collector: follows the window position (x, y, scale) of every classified window
// using the row/scale end markers, and queues positive detections plus the frame's final
// window as coordinate records on a valid/ready stream.
// Optional build macro DETECTION_COLLECTOR_STATS_EN adds the per-frame hit count frame_hits.
module detection_collector #(
   parameter int IMG_WIDTH      = 45,
   parameter int IMG_HEIGHT     = 45,
   parameter int FEATURE_WIDTH  = 25,
   parameter int FEATURE_HEIGHT = 25,
   parameter int SCALE_NUM      = 2,
   parameter int FIFO_DEPTH     = 8,
   localparam int W_X = $clog2(IMG_WIDTH - FEATURE_WIDTH + 1),
   localparam int W_Y = $clog2(IMG_HEIGHT - FEATURE_HEIGHT + 1),
   localparam int W_S = (SCALE_NUM > 1) ? $clog2(SCALE_NUM) : 1
`ifdef DETECTION_COLLECTOR_STATS_EN
   ,
   localparam int W_FH = $clog2(SCALE_NUM * (IMG_WIDTH - FEATURE_WIDTH + 1)
                                * (IMG_HEIGHT - FEATURE_HEIGHT + 1) + 1)
`endif
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           result_valid,
   output logic           result_ready,
   input  logic           result_data,
   input  logic [1:0]     result_eot,
   output logic           det_valid,
   input  logic           det_ready,
   output logic [W_X-1:0] det_x,
   output logic [W_Y-1:0] det_y,
   output logic [W_S-1:0] det_scale,
   output logic           det_hit,
   output logic           det_last,
   output logic           err_geom
`ifdef DETECTION_COLLECTOR_STATS_EN
   ,
   output logic [W_FH-1:0] frame_hits
`endif
);

   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW    = AW + 1;
   localparam int REC_W = W_X + W_Y + W_S + 2;

   localparam logic [W_X-1:0] X_MAX    = W_X'(IMG_WIDTH - FEATURE_WIDTH);
   localparam logic [W_Y-1:0] Y_MAX    = W_Y'(IMG_HEIGHT - FEATURE_HEIGHT);
   localparam logic [W_S-1:0] S_LAST   = W_S'(SCALE_NUM - 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

   logic [W_X-1:0] x_q, x_d;
   logic [W_Y-1:0] y_q, y_d;
   logic [W_S-1:0] scale_q, scale_d;
   logic           err_d;
   logic           accept, frame_end, push, pop;

   logic [REC_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;

   assign result_ready = (count_q != FULL_CNT);
   assign {det_x, det_y, det_scale, det_hit, det_last} = mem_q[rd_ptr_q];

   // Handshakes, record push decision and next window position
   always_comb begin
      accept    = result_valid && result_ready;
      frame_end = result_eot[1] && (scale_q == S_LAST);
      push      = accept && (result_data || frame_end);
      pop       = det_valid && det_ready;
      x_d       = x_q;
      y_d       = y_q;
      scale_d   = scale_q;
      err_d     = err_geom;
      if (accept) begin
         if (result_eot[1]) begin
            // A scale end without a row end is still honoured as a scale end
            x_d     = '0;
            y_d     = '0;
            scale_d = frame_end ? '0 : scale_q + 1'b1;
            if (!result_eot[0]) err_d = 1'b1;
         end else if (result_eot[0]) begin
            x_d = '0;
            if (y_q == Y_MAX) err_d = 1'b1;
            else              y_d = y_q + 1'b1;
         end else begin
            if (x_q == X_MAX) err_d = 1'b1;
            else              x_d = x_q + 1'b1;
         end
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Window position counters and sticky geometry error
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q      <= '0;
         y_q      <= '0;
         scale_q  <= '0;
         err_geom <= 1'b0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         scale_q  <= scale_d;
         err_geom <= err_d;
      end
   end

   // Record FIFO; the head entry drives det_* directly from storage
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         det_valid <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {x_q, y_q, scale_q, result_data, frame_end};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q   <= count_d;
         det_valid <= (count_d != '0);
      end
   end

`ifdef DETECTION_COLLECTOR_STATS_EN
   logic [W_FH-1:0] hit_cnt_q, hit_inc;

   assign hit_inc = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;

   // Per-frame positive count, published on the frame's final accept
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         frame_hits <= '0;
      end else if (accept) begin
         if (frame_end) begin
            frame_hits <= result_data ? hit_inc : hit_cnt_q;
            hit_cnt_q  <= '0;
         end else if (result_data) begin
            hit_cnt_q <= hit_inc;
         end
      end
   end
`endif

endmodule

// File: tb/tb_detection_collector.sv
// tb_detection_collector: table-driven vectors, directed corner sequences and randomized
// frames checked against a queue-based reference of expected records.
module tb_detection_collector;

   localparam int DEPTH = 8;
   localparam int W_X   = $clog2(45 - 25 + 1);
   localparam int W_Y   = $clog2(45 - 25 + 1);
   localparam int W_S   = 1;
`ifdef DETECTION_COLLECTOR_STATS_EN
   localparam int W_FH  = $clog2(2 * 21 * 21 + 1);
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic           result_valid, result_ready, result_data;
   logic [1:0]     result_eot;
   logic           det_valid, det_ready;
   logic [W_X-1:0] det_x;
   logic [W_Y-1:0] det_y;
   logic [W_S-1:0] det_scale;
   logic           det_hit, det_last, err_geom;
`ifdef DETECTION_COLLECTOR_STATS_EN
   logic [W_FH-1:0] frame_hits;
`endif

   detection_collector dut (
      .clk          (clk),
      .rst          (rst),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_data  (result_data),
      .result_eot   (result_eot),
      .det_valid    (det_valid),
      .det_ready    (det_ready),
      .det_x        (det_x),
      .det_y        (det_y),
      .det_scale    (det_scale),
      .det_hit      (det_hit),
      .det_last     (det_last),
      .err_geom     (err_geom)
`ifdef DETECTION_COLLECTOR_STATS_EN
      ,
      .frame_hits   (frame_hits)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int s;
      bit hit;
      bit last;
   } rec_t;

   typedef struct {
      bit       v;
      bit       d;
      bit [1:0] eot;
      bit       dr;
      bit       edv;
      int       ex;
      int       ey;
      int       es;
      bit       eh;
      bit       el;
      bit       eerr;
   } vec_t;

   int   n_pass = 0;
   int   n_total = 0;
   int   n_popped = 0;
   int   ready_pct = 100;
   int   gap_pct = 0;
   bit   sb_on = 1'b0;
   rec_t exp_q[$];
   rec_t cur_exp;
   bit   cur_push;

   function automatic void chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endfunction

   function automatic vec_t mk(input bit v, input bit d, input bit [1:0] eot, input bit dr,
                               input bit edv, input int ex, input int ey, input int es,
                               input bit eh, input bit el, input bit eerr);
      vec_t t;
      t.v = v; t.d = d; t.eot = eot; t.dr = dr; t.edv = edv;
      t.ex = ex; t.ey = ey; t.es = es; t.eh = eh; t.el = el; t.eerr = eerr;
      return t;
   endfunction

   // One clock: compare the stream against the expected-record queue, then advance.
   task automatic tick(output bit acc);
      rec_t r;
      @(negedge clk);
      acc = result_valid && result_ready;
      if (sb_on) begin
         chk("result_ready", int'(result_ready), int'(exp_q.size() < DEPTH));
         chk("det_valid", int'(det_valid), int'(exp_q.size() != 0));
         if (det_valid && det_ready && exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("det_x", int'(det_x), r.x);
            chk("det_y", int'(det_y), r.y);
            chk("det_scale", int'(det_scale), r.s);
            chk("det_hit", int'(det_hit), int'(r.hit));
            chk("det_last", int'(det_last), int'(r.last));
            n_popped++;
         end
         if (acc && cur_push) exp_q.push_back(cur_exp);
      end
      @(posedge clk);
      #1;
      if (sb_on) det_ready = (int'($urandom_range(99)) < ready_pct);
   endtask

   // Present one window whose true position the caller knows.
   task automatic send(input bit d, input bit [1:0] eot, input int ex, input int ey,
                       input int es, input bit last);
      bit acc = 1'b0;
      bit dummy;
      result_valid = 1'b1;
      result_data  = d;
      result_eot   = eot;
      cur_exp      = '{ex, ey, es, d, last};
      cur_push     = d || last;
      for (int i = 0; i < 500 && !acc; i++) tick(acc);
      chk("accept_timeout", int'(acc), 1);
      result_valid = 1'b0;
      result_data  = 1'b0;
      result_eot   = 2'b00;
      for (int i = 0; i < 3; i++)
         if (int'($urandom_range(99)) < gap_pct) tick(dummy);
   endtask

   task automatic drain();
      bit acc;
      ready_pct = 100;
      det_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(acc);
      tick(acc);
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // A full two-scale frame of c0 x r0 then c1 x r1 windows.
   task automatic frame(input int c0, input int r0, input int c1, input int r1,
                        input int hit_pct);
      int       hits = 0;
      int       cols, rows;
      bit [1:0] eot;
      bit       d;
      for (int s = 0; s < 2; s++) begin
         cols = (s == 0) ? c0 : c1;
         rows = (s == 0) ? r0 : r1;
         for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
               eot[0] = (x == cols - 1);
               eot[1] = eot[0] && (y == rows - 1);
               d      = (int'($urandom_range(99)) < hit_pct);
               hits  += int'(d);
               send(d, eot, x, y, s, (s == 1) && eot[1]);
            end
         end
      end
      chk("frame_err", int'(err_geom), 0);
`ifdef DETECTION_COLLECTOR_STATS_EN
      chk("frame_hits", int'(frame_hits), hits);
`endif
   endtask

   task automatic do_reset();
      sb_on        = 1'b0;
      rst          = 1'b1;
      result_valid = 1'b0;
      result_data  = 1'b0;
      result_eot   = 2'b00;
      det_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      sb_on = 1'b1;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[19];
      int   p0;
      bit   acc;
      bit   hm [8];

      // inputs v d eot dr | expected det_valid x y scale hit last err (before this edge)
      vecs[0]  = mk(1, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(1, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[3]  = mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[4]  = mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[5]  = mk(1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mk(1, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[7]  = mk(0, 0, 2'b00, 1, 1, 4, 2, 0, 1, 0, 0);
      vecs[8]  = mk(1, 1, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[9]  = mk(1, 0, 2'b11, 1, 1, 5, 2, 0, 1, 0, 0);
      vecs[10] = mk(1, 0, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 0, 2'b00, 1, 1, 0, 0, 1, 0, 1, 0);
      vecs[12] = mk(1, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0);
      vecs[13] = mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1);
      vecs[14] = mk(1, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0, 1);
      vecs[15] = mk(0, 0, 2'b00, 0, 1, 0, 0, 1, 1, 1, 1);
      vecs[16] = mk(0, 0, 2'b00, 0, 1, 0, 0, 1, 1, 1, 1);
      vecs[17] = mk(0, 0, 2'b00, 1, 1, 0, 0, 1, 1, 1, 1);
      vecs[18] = mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1);

      do_reset();
      chk("rst_det_valid", int'(det_valid), 0);
      chk("rst_err_geom", int'(err_geom), 0);
      chk("rst_result_ready", int'(result_ready), 1);
      chk("rst_det_x", int'(det_x), 0);
      chk("rst_det_y", int'(det_y), 0);
      chk("rst_det_scale", int'(det_scale), 0);
      chk("rst_det_hit", int'(det_hit), 0);
      chk("rst_det_last", int'(det_last), 0);
`ifdef DETECTION_COLLECTOR_STATS_EN
      chk("rst_frame_hits", int'(frame_hits), 0);
`endif

      // Table-driven vectors
      sb_on = 1'b0;
      for (int i = 0; i < 19; i++) begin
         result_valid = vecs[i].v;
         result_data  = vecs[i].d;
         result_eot   = vecs[i].eot;
         det_ready    = vecs[i].dr;
         @(negedge clk);
         chk("vec_result_ready", int'(result_ready), 1);
         chk("vec_det_valid", int'(det_valid), int'(vecs[i].edv));
         chk("vec_err_geom", int'(err_geom), int'(vecs[i].eerr));
         if (vecs[i].edv) begin
            chk("vec_det_x", int'(det_x), vecs[i].ex);
            chk("vec_det_y", int'(det_y), vecs[i].ey);
            chk("vec_det_scale", int'(det_scale), vecs[i].es);
            chk("vec_det_hit", int'(det_hit), int'(vecs[i].eh));
            chk("vec_det_last", int'(det_last), int'(vecs[i].el));
         end
         @(posedge clk);
         #1;
      end

      // All-negative frame: only the final window produces a record
      do_reset();
      ready_pct = 100;
      gap_pct   = 0;
      p0        = n_popped;
      frame(21, 21, 7, 5, 0);
      drain();
      chk("neg_frame_records", n_popped - p0, 1);

      // Column overflow saturates x and sets the sticky error
      do_reset();
      for (int x = 0; x < 20; x++) send(0, 2'b00, x, 0, 0, 0);
      chk("err_before_sat", int'(err_geom), 0);
      send(0, 2'b00, 20, 0, 0, 0);
      chk("err_at_sat", int'(err_geom), 1);
      send(1, 2'b00, 20, 0, 0, 0);
      send(0, 2'b01, 20, 0, 0, 0);
      send(1, 2'b00, 0, 1, 0, 0);
      drain();
      chk("err_sticky", int'(err_geom), 1);
      do_reset();
      chk("err_cleared", int'(err_geom), 0);

      // FIFO fill with consumer stalled, then release
      do_reset();
      ready_pct = 0;
      det_ready = 1'b0;
      p0        = n_popped;
      for (int x = 0; x < 8; x++) send(1, 2'b00, x, 0, 0, 0);
      chk("ready_full", int'(result_ready), 0);
      tick(acc);
      tick(acc);
      ready_pct = 100;
      det_ready = 1'b1;
      send(1, 2'b00, 8, 0, 0, 0);
      drain();
      chk("full_records", n_popped - p0, 9);

      // Reset with records queued mid-frame
      do_reset();
      ready_pct = 0;
      det_ready = 1'b0;
      send(0, 2'b01, 0, 0, 0, 0);
      for (int x = 0; x < 3; x++) send(1, 2'b00, x, 1, 0, 0);
      tick(acc);
      chk("queued_valid", int'(det_valid), 1);
      sb_on = 1'b0;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", int'(det_valid), 0);
      rst = 1'b0;
      exp_q.delete();
      sb_on     = 1'b1;
      ready_pct = 100;
      det_ready = 1'b1;
      send(1, 2'b00, 0, 0, 0, 0);
      drain();

`ifdef DETECTION_COLLECTOR_STATS_EN
      // Five positives with the final window positive, then an empty frame
      do_reset();
      hm = '{1, 1, 1, 1, 0, 0, 0, 1};
      for (int i = 0; i < 8; i++) begin
         send(hm[i], (i % 4 == 3) ? 2'b11 : ((i % 2 == 1) ? 2'b01 : 2'b00),
              i % 2, (i % 4) / 2, i / 4, i == 7);
      end
      chk("frame_hits_5", int'(frame_hits), 5);
      drain();
      frame(2, 2, 2, 2, 0);
      drain();
`else
      hm = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

      // Randomized frames with random gaps and back-pressure
      do_reset();
      ready_pct = 60;
      gap_pct   = 20;
      for (int f = 0; f < 3; f++) begin
         frame(int'($urandom_range(21, 1)), int'($urandom_range(21, 1)),
               int'($urandom_range(21, 1)), int'($urandom_range(21, 1)), 30);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
